router_reg_gen: RTL

- Parametrised next-generation register/checker stage of the router datapath. Sits between the input FSM and the output FIFOs.
- Captures the header, forwards payload to `dout`, and holds the word that arrives while the FIFO is full.
- Accumulates a configurable packet checksum (XOR or modular sum) and compares it with the trailing check word.
- Optionally checks the received payload count against the length field in the header, and reports parity and length errors separately.

---
 rtl/router_reg_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/router_reg_gen.sv
// -----------------------------------------------------------------------------
// router_reg_gen
//
// Register/checker stage between the router input FSM and the output FIFOs.
// Captures the packet header and forwards it, then the payload, to dout. It
// holds the word that arrives while the destination FIFO is full and replays
// that word in laf_state. It accumulates a packet checksum (XOR or modular
// sum) and compares it with the trailing check word. It can also compare the
// payload word count with the length field of the header.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   pkt_valid           : high for header/payload, low when data_in is the check word
//   data_in [WIDTH]     : incoming word
//   fifo_full           : selected destination FIFO is full
//   detect_add, lfd_state, ld_state, laf_state, full_state
//                       : one-hot FSM state decodes (at most one high)
//   rst_int_reg         : FSM request to clear low_pkt_valid
//   dout [WIDTH]        : word presented to the FIFO
//   parity_done         : check word has been captured
//   low_pkt_valid       : pkt_valid fell during ld_state
//   err                 : err_par | err_len
//   err_par             : checksum mismatch (sticky until detect_add)
//   err_len             : payload count differs from header length (sticky)
//   pkt_done            : one-cycle pulse, the cycle after parity_done rises
//   pay_cnt [WIDTH-ADDR_BITS] : payload words accepted, saturating
// -----------------------------------------------------------------------------
module router_reg_gen #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 2,
    parameter int CHK_MODE  = 0,
    parameter int LEN_CHECK = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pkt_valid,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       fifo_full,
    input  logic                       detect_add,
    input  logic                       lfd_state,
    input  logic                       ld_state,
    input  logic                       laf_state,
    input  logic                       full_state,
    input  logic                       rst_int_reg,
    output logic [WIDTH-1:0]           dout,
    output logic                       parity_done,
    output logic                       low_pkt_valid,
    output logic                       err,
    output logic                       err_par,
    output logic                       err_len,
    output logic                       pkt_done,
    output logic [WIDTH-ADDR_BITS-1:0] pay_cnt
);

    localparam int CW = WIDTH - ADDR_BITS;

    logic [WIDTH-1:0] hdr_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_is_chk;
    logic [WIDTH-1:0] chk_acc;
    logic [WIDTH-1:0] pkt_chk;
    logic [CW-1:0]    exp_len;
    logic             parity_done_d;
    logic [CW-1:0]    pay_cnt_inc;
    logic             parity_rise;

    // Sum mode drops the carry-out, so the checksum wraps at 2^WIDTH.
    function automatic logic [WIDTH-1:0] chk_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return (CHK_MODE != 0) ? (a + b) : (a ^ b);
    endfunction

    // The counter saturates instead of wrapping. An oversize packet therefore
    // still mismatches a shorter header length.
    assign pay_cnt_inc = (pay_cnt == '1) ? pay_cnt : pay_cnt + 1'b1;
    assign parity_rise = parity_done && !parity_done_d;
    assign err         = err_par | err_len;

    always_ff @(posedge clock) begin
        if (reset) begin
            dout          <= '0;
            parity_done   <= 1'b0;
            parity_done_d <= 1'b0;
            low_pkt_valid <= 1'b0;
            err_par       <= 1'b0;
            err_len       <= 1'b0;
            pkt_done      <= 1'b0;
            pay_cnt       <= '0;
            hdr_reg       <= '0;
            hold_reg      <= '0;
            hold_is_chk   <= 1'b0;
            chk_acc       <= '0;
            pkt_chk       <= '0;
            exp_len       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every condition
            // below sees the register values from before this edge.
            if (detect_add) begin
                if (pkt_valid) begin
                    hdr_reg <= data_in;
                end
                chk_acc     <= '0;
                pkt_chk     <= '0;
                pay_cnt     <= '0;
                parity_done <= 1'b0;
                hold_is_chk <= 1'b0;
            end else if (lfd_state) begin
                dout    <= hdr_reg;
                chk_acc <= hdr_reg;
                exp_len <= hdr_reg[WIDTH-1:ADDR_BITS];
            end else if (ld_state) begin
                if (fifo_full) begin
                    // Park the word. laf_state replays it once the FIFO drains.
                    hold_reg    <= data_in;
                    hold_is_chk <= !pkt_valid;
                end else begin
                    dout <= data_in;
                    if (pkt_valid) begin
                        chk_acc <= chk_op(chk_acc, data_in);
                        pay_cnt <= pay_cnt_inc;
                    end else begin
                        pkt_chk     <= data_in;
                        parity_done <= 1'b1;
                    end
                end
            end else if (laf_state) begin
                dout <= hold_reg;
                if (!parity_done) begin
                    if (hold_is_chk) begin
                        pkt_chk     <= hold_reg;
                        parity_done <= 1'b1;
                    end else begin
                        chk_acc <= chk_op(chk_acc, hold_reg);
                        pay_cnt <= pay_cnt_inc;
                    end
                end
            end else if (!full_state && rst_int_reg && !pkt_valid) begin
                // No capture this cycle, so the checker state can be dropped.
                chk_acc <= '0;
                pkt_chk <= '0;
            end

            // If the set and the clear request arrive together, the set wins.
            if (!detect_add && !lfd_state && ld_state && !pkt_valid) begin
                low_pkt_valid <= 1'b1;
            end else if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end

            // Errors are judged one cycle after the check word lands, when
            // pkt_chk and chk_acc both hold their final values.
            parity_done_d <= parity_done;
            pkt_done      <= parity_rise;
            if (detect_add) begin
                err_par <= 1'b0;
                err_len <= 1'b0;
            end else if (parity_rise) begin
                err_par <= (pkt_chk != chk_acc);
                err_len <= (LEN_CHECK != 0) && (pay_cnt != exp_len);
            end
        end
    end

endmodule
